e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU (range 1..63).
REQ-003 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU (range 1..63).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port E_start  input  1  operation request, valid for one cycle.
REQ-007 SHALL have port E_MDUOp  input  3  op code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
REQ-008 SHALL have port A  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
REQ-009 SHALL have port B  input  WIDTH  rt operand (divisor / multiplier).
REQ-010 SHALL have port E_busy  output  1  registered; high while an operation is in flight.
REQ-011 SHALL have port E_done  output  1  registered; one-cycle pulse after HI/LO are written by MULT/DIV.
REQ-012 SHALL have port E_HI  output  WIDTH  current HI register, for MFHI.
REQ-013 SHALL have port E_LO  output  WIDTH  current LO register, for MFLO.

Function
REQ-014 SHALL accept a request at a rising edge only when E_start=1 and E_busy=0; a request while E_busy=1 SHALL be ignored entirely.
REQ-015 SHALL, on an accepted MULT/MULTU/DIV/DIVU, capture A, B and the op, load a counter with the op latency N, and assert E_busy from the next cycle for exactly N cycles.
REQ-016 SHALL write HI/LO at the edge that ends the Nth busy cycle; E_busy SHALL deassert at that same edge, and E_done SHALL be high for the following cycle only.
REQ-017 SHALL hold HI/LO unchanged while busy; E_HI/E_LO SHALL show the old values until the write edge.
REQ-018 SHALL, for MULT, form the signed 2*WIDTH product with HI = upper WIDTH bits and LO = lower WIDTH bits; MULTU SHALL do the same unsigned.
REQ-019 SHALL, for DIV, set LO to the signed quotient truncated toward zero and HI to the remainder, which takes the sign of the dividend.
REQ-020 SHALL, for DIV with A = -2^(WIDTH-1) and B = -1, set LO = -2^(WIDTH-1) and HI = 0.
REQ-021 SHALL, for DIVU, set LO and HI to the unsigned quotient and remainder.
REQ-022 SHALL, for DIV/DIVU with B = 0, still run the full busy/done sequence but leave HI and LO unchanged.
REQ-023 SHALL, on an accepted MTHI/MTLO, write A into HI/LO at that same edge, with no busy cycle and no E_done.
REQ-024 SHALL treat NOP, or E_start=0, as no state change.
REQ-025 SHALL compute results from the captured operands only; A/B changes after acceptance SHALL have no effect.
REQ-026 SHALL be a two-state FSM: IDLE -> RUN on accepted MULT/DIV; RUN -> IDLE when the counter reaches 1 at the edge.

Reset
REQ-027 SHALL, on reset=1 (asynchronous), immediately clear HI, LO, the counter, E_busy and E_done to 0 and enter IDLE.
REQ-028 SHALL discard an in-flight operation on reset; no HI/LO write and no E_done pulse SHALL follow.

Configuration
REQ-029 SHALL, when macro MDU_DIV_EN is defined, implement DIV/DIVU as specified above.
REQ-030 SHALL, when MDU_DIV_EN is undefined, contain no divider logic and treat DIV/DIVU as NOP: no busy, no done, HI/LO unchanged.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10, MDU_DIV_EN defined)
REQ-031 MULT with A=0xFFFFFFFF, B=2 -> E_busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, and one E_done pulse.
REQ-032 MULTU with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-033 DIV with A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 MTHI A=0x1234, then DIVU with B=0 -> E_busy high for 10 cycles, E_done pulses, HI stays 0x1234.
REQ-035 MULT accepted, then MTLO A=0x55 issued on busy cycle 2 -> MTLO ignored, LO equals the product after completion.
REQ-036 Reset asserted mid-cycle during DIV busy cycle 4 -> E_busy, HI, LO read 0 at once, and no E_done follows.

Source files
------------

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Divider is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU behave as NOP.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E_start,
    input  logic [2:0]       E_MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             E_busy,
    output logic             E_done,
    output logic [WIDTH-1:0] E_HI,
    output logic [WIDTH-1:0] E_LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [5:0]       cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             accept_long;

    function automatic logic is_long(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic [5:0] latency(input logic [2:0] op);
        return ((op == OP_DIV) || (op == OP_DIVU)) ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
    endfunction

    // Full 2*WIDTH product; operands are sign- or zero-extended before the multiply.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic sgn);
        logic signed [2*WIDTH-1:0] xs;
        logic signed [2*WIDTH-1:0] ys;
        logic signed [2*WIDTH-1:0] p;
        xs = sgn ? $signed({{WIDTH{x[WIDTH-1]}}, x}) : $signed({{WIDTH{1'b0}}, x});
        ys = sgn ? $signed({{WIDTH{y[WIDTH-1]}}, y}) : $signed({{WIDTH{1'b0}}, y});
        p  = xs * ys;
        return p;
    endfunction

`ifdef MDU_DIV_EN
    // Returns {remainder, quotient}; MIN / -1 saturates to MIN with zero remainder.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic sgn);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [WIDTH-1:0]        q;
        logic [WIDTH-1:0]        r;
        logic [WIDTH-1:0]        min_v;
        min_v = {1'b1, {(WIDTH-1){1'b0}}};
        xs    = $signed(x);
        ys    = $signed(y);
        if (!sgn) begin
            q = x / y;
            r = x % y;
        end else if ((x == min_v) && (y == {WIDTH{1'b1}})) begin
            q = min_v;
            r = '0;
        end else begin
            q = xs / ys;
            r = xs % ys;
        end
        return {r, q};
    endfunction
`endif

    assign accept_long = E_start && (state == IDLE) && is_long(E_MDUOp);

    // Operand capture: data path only, not reset.
    always_ff @(posedge clk) begin
        if (accept_long) begin
            op_q <= E_MDUOp;
            a_q  <= A;
            b_q  <= B;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            E_busy <= 1'b0;
            E_done <= 1'b0;
            E_HI   <= '0;
            E_LO   <= '0;
        end else begin
            E_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_long) begin
                        state  <= RUN;
                        cnt    <= latency(E_MDUOp);
                        E_busy <= 1'b1;
                    end else if (E_start && (E_MDUOp == OP_MTHI)) begin
                        E_HI <= A;
                    end else if (E_start && (E_MDUOp == OP_MTLO)) begin
                        E_LO <= A;
                    end
                end
                RUN: begin
                    if (cnt == 6'd1) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        E_busy <= 1'b0;
                        E_done <= 1'b1;
                        if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
                            {E_HI, E_LO} <= mul_full(a_q, b_q, op_q == OP_MULT);
                        end
`ifdef MDU_DIV_EN
                        // Divide by zero completes normally but leaves HI/LO untouched.
                        else if (b_q != '0) begin
                            {E_HI, E_LO} <= div_full(a_q, b_q, op_q == OP_DIV);
                        end
`endif
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expected HI/LO, a monitor checks them on E_done.
module tb_e_mdu;

`ifdef MDU_DIV_EN
    localparam int DIVC = 10;
`else
    localparam int DIVC = 0;
`endif

    logic        clk;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        E_busy;
    logic        E_done;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_start(E_start), .E_MDUOp(E_MDUOp),
        .A(A), .B(B), .E_busy(E_busy), .E_done(E_done), .E_HI(E_HI), .E_LO(E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          pushes = 0;
    int          pops = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    string       tname = "init";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every E_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && E_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexpected_done actual=done required=no_done", tname);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                pops++;
                chk({tname, "_hi"}, {32'b0, E_HI}, {32'b0, e[63:32]});
                chk({tname, "_lo"}, {32'b0, E_LO}, {32'b0, e[31:0]});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_start = 1'b1;
        E_MDUOp = op;
        A = a;
        B = b;
        @(negedge clk);
        E_start = 1'b0;
        E_MDUOp = 3'd0;
        A = ~a;
        B = ~b;
    endtask

    task automatic long_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int ncyc,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        tname = name;
        if (ncyc > 0) begin
            exp_q.push_back({ehi, elo});
            pushes++;
        end
        issue(op, a, b);
        if (ncyc == 0) begin
            chk({name, "_nop_busy"}, {63'b0, E_busy}, 64'd0);
            chk({name, "_nop_hi"}, {32'b0, E_HI}, {32'b0, hi_m});
            chk({name, "_nop_lo"}, {32'b0, E_LO}, {32'b0, lo_m});
        end else begin
            n = 0;
            while (E_busy && n < 200) begin
                n++;
                if (n == 1) chk({name, "_hi_held"}, {32'b0, E_HI}, {32'b0, hi_m});
                @(negedge clk);
            end
            chk({name, "_busy_cycles"}, 64'(n), 64'(ncyc));
            chk({name, "_done_high"}, {63'b0, E_done}, 64'd1);
            @(negedge clk);
            chk({name, "_done_width"}, {63'b0, E_done}, 64'd0);
            hi_m = ehi;
            lo_m = elo;
        end
    endtask

    task automatic short_op(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] ehi, input logic [31:0] elo);
        tname = name;
        issue(op, a, 32'h0000_0005);
        chk({name, "_busy"}, {63'b0, E_busy}, 64'd0);
        chk({name, "_hi"}, {32'b0, E_HI}, {32'b0, ehi});
        chk({name, "_lo"}, {32'b0, E_LO}, {32'b0, elo});
        @(negedge clk);
        chk({name, "_no_done"}, {63'b0, E_done}, 64'd0);
        hi_m = ehi;
        lo_m = elo;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        E_start = 1'b0;
        E_MDUOp = 3'd0;
        A = '0;
        B = '0;
        hi_m = '0;
        lo_m = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'b0, E_busy}, 64'd0);
        chk("rst_done", {63'b0, E_done}, 64'd0);
        chk("rst_hi", {32'b0, E_HI}, 64'd0);
        chk("rst_lo", {32'b0, E_LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        long_op("mult_m1x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        long_op("multu_maxx2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        long_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, DIVC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        long_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIVC, 32'h0, 32'h8000_0000);
        long_op("divu_100_7", 3'd4, 32'd100, 32'd7, DIVC, 32'd2, 32'd14);
        long_op("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, DIVC, 32'd1, 32'hFFFF_FFFD);

        short_op("mthi", 3'd5, 32'h0000_1234, 32'h0000_1234, lo_m);
        short_op("mtlo", 3'd6, 32'h0000_ABCD, hi_m, 32'h0000_ABCD);
        long_op("divu_by0", 3'd4, 32'd5, 32'd0, DIVC, hi_m, lo_m);
        short_op("nop0", 3'd0, 32'hDEAD_BEEF, hi_m, lo_m);
        short_op("nop7", 3'd7, 32'hDEAD_BEEF, hi_m, lo_m);

        // MULT 3 * -4 with an MTLO request arriving on busy cycle 2.
        tname = "mult_mtlo_busy";
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF4});
        pushes++;
        E_start = 1'b1; E_MDUOp = 3'd1; A = 32'd3; B = 32'hFFFF_FFFC;
        @(negedge clk);
        E_start = 1'b0; E_MDUOp = 3'd0; A = 32'h0000_DEAD; B = 32'd1;
        n = 0;
        while (E_busy && n < 200) begin
            n++;
            if (n == 2) begin
                E_start = 1'b1; E_MDUOp = 3'd6; A = 32'h0000_0055;
            end else begin
                E_start = 1'b0; E_MDUOp = 3'd0;
            end
            if (n == 3) chk("mult_mtlo_lo_held", {32'b0, E_LO}, {32'b0, lo_m});
            @(negedge clk);
        end
        E_start = 1'b0;
        chk("mult_mtlo_busy_cycles", 64'(n), 64'd5);
        @(negedge clk);
        chk("mult_mtlo_lo_after", {32'b0, E_LO}, 64'h0000_0000_FFFF_FFF4);
        hi_m = 32'hFFFF_FFFF;
        lo_m = 32'hFFFF_FFF4;

        // Asynchronous reset in the middle of busy cycle 4.
        tname = "rst_midop";
`ifdef MDU_DIV_EN
        issue(3'd3, 32'd100, 32'd7);
`else
        issue(3'd1, 32'd100, 32'd7);
`endif
        repeat (3) @(negedge clk);
        chk("rst_midop_busy_before", {63'b0, E_busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_midop_busy", {63'b0, E_busy}, 64'd0);
        chk("rst_midop_hi", {32'b0, E_HI}, 64'd0);
        chk("rst_midop_lo", {32'b0, E_LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_midop_no_done", 64'(pops), 64'(pushes));
        chk("rst_midop_hi_after", {32'b0, E_HI}, 64'd0);
        chk("rst_midop_busy_after", {63'b0, E_busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
